id_exe_reg: RTL and testbench
=============================

ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC and register-value fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port freeze  input  1  hazard stall; hold all stored fields.
REQ-005 SHALL have port flush  input  1  branch-taken squash; insert bubble.
REQ-006 SHALL have port valid_in  input  1  ID stage presents a real instruction.
REQ-007 SHALL have ports pc_in, val_rn_in, val_rm_in  input  DATA_W each  PC+4 and register operands from ID.
REQ-008 SHALL have ports shift_operand_in 12, imm_in 1, signed_imm24_in 24, dest_in 4, src1_in 4, src2_in 4  input  instruction fields.
REQ-009 SHALL have ports exe_cmd_in 4, mem_r_en_in 1, mem_w_en_in 1, wb_en_in 1, b_in 1, s_in 1, status_in 4 (N,Z,C,V)  input  control and flags.
REQ-010 SHALL have a matching registered output for every input of REQ-006..REQ-009, suffix _out instead of _in, same width.
REQ-011 SHALL have port bubble_cnt  output  8  saturating count of bubbles inserted since reset.

Function
REQ-012 Each output SHALL be a flip-flop; no combinational input-to-output path.
REQ-013 Latency SHALL be exactly one clock: input sampled at edge k appears on outputs after edge k.
REQ-014 Priority per edge SHALL be rst > flush > freeze > load.
REQ-015 Load (no rst, flush, freeze): all _out fields SHALL take their _in values.
REQ-016 Freeze (no rst, flush): all _out fields SHALL hold previous values; bubble_cnt unchanged.
REQ-017 Flush (no rst): valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out SHALL clear to 0; data fields SHALL clear to 0 as well.
REQ-018 Flush asserted together with freeze SHALL behave as flush (branch squash overrides stall).
REQ-019 A flush or a load with valid_in=0 SHALL count as a bubble: bubble_cnt increments by 1.
REQ-020 bubble_cnt SHALL saturate at 255 and never wrap to 0.
REQ-021 status_out SHALL be captured with the same rules as other fields; it SHALL NOT be modified by s_in.
REQ-022 Load with valid_in=0 SHALL still force wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out to 0 regardless of their inputs.
REQ-023 Field widths SHALL pass through unchanged; no sign extension or truncation in this block.
REQ-024 Freeze held for N consecutive edges SHALL keep outputs constant for all N cycles, then load on the first edge with freeze=0.

Reset
REQ-025 On rising edge with rst=1 every output, including bubble_cnt, SHALL become 0.
REQ-026 rst asserted mid-freeze or mid-flush SHALL override both; first edge after rst release SHALL perform a normal load/freeze/flush decision.
REQ-027 Reset SHALL take effect only at a clock edge; asserting rst between edges SHALL not change outputs.

Verification
REQ-028 Load: valid_in=1, pc_in=0x00000008, val_rm_in=0x12345678, shift_operand_in=0x0A3, wb_en_in=1 -> next cycle outputs equal inputs, bubble_cnt=0.
REQ-029 Freeze: load pc_in=0x10, then freeze=1 for 3 edges with pc_in=0x14 -> pc_out stays 0x10 three cycles, then 0x14 after freeze drops.
REQ-030 Flush vs freeze: valid_in=1, wb_en_in=1, mem_w_en_in=1, flush=1, freeze=1 -> valid_out=0, wb_en_out=0, mem_w_en_out=0, bubble_cnt +1.
REQ-031 Invalid load: valid_in=0, mem_r_en_in=1, b_in=1 -> mem_r_en_out=0, b_out=0, bubble_cnt +1.
REQ-032 Saturation: 300 consecutive flush edges -> bubble_cnt=255, stays 255 on further flushes.
REQ-033 Reset mid-stall: freeze=1 with stored pc_out=0x20, rst=1 one edge -> all outputs 0; next edge with valid_in=1 loads normally.

Source files
------------

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: one-cycle capture of decoded instruction fields with
// stall (freeze), squash (flush) and a saturating count of inserted bubbles.
module id_exe_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic              imm_in,
    input  logic [23:0]       signed_imm24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        status_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [11:0]       shift_operand_out,
    output logic              imm_out,
    output logic [23:0]       signed_imm24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [3:0]        exe_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [3:0]        status_out,
    output logic [7:0]        bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [11:0]       shift_operand;
        logic              imm;
        logic [23:0]       signed_imm24;
        logic [3:0]        dest;
        logic [3:0]        src1;
        logic [3:0]        src2;
        logic [3:0]        exe_cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic              b;
        logic              s;
        logic [3:0]        status;
    } stage_t;

    stage_t     stage_in;
    stage_t     stage_d, stage_q;
    logic [7:0] bubble_cnt_d, bubble_cnt_q;
    logic [7:0] bubble_cnt_inc;

    always_comb begin
        stage_in.valid         = valid_in;
        stage_in.pc            = pc_in;
        stage_in.val_rn        = val_rn_in;
        stage_in.val_rm        = val_rm_in;
        stage_in.shift_operand = shift_operand_in;
        stage_in.imm           = imm_in;
        stage_in.signed_imm24  = signed_imm24_in;
        stage_in.dest          = dest_in;
        stage_in.src1          = src1_in;
        stage_in.src2          = src2_in;
        stage_in.exe_cmd       = exe_cmd_in;
        stage_in.mem_r_en      = mem_r_en_in;
        stage_in.mem_w_en      = mem_w_en_in;
        stage_in.wb_en         = wb_en_in;
        stage_in.b             = b_in;
        stage_in.s             = s_in;
        stage_in.status        = status_in;
    end

    assign bubble_cnt_inc = (bubble_cnt_q == 8'hFF) ? bubble_cnt_q : bubble_cnt_q + 8'd1;

    // Flush wins over freeze so a taken branch can squash a stalled instruction.
    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            stage_d      = '0;
            bubble_cnt_d = bubble_cnt_inc;
        end else if (!freeze) begin
            stage_d = stage_in;
            if (!valid_in) begin
                // Invalid slot must not have side effects downstream.
                stage_d.mem_r_en = 1'b0;
                stage_d.mem_w_en = 1'b0;
                stage_d.wb_en    = 1'b0;
                stage_d.b        = 1'b0;
                stage_d.s        = 1'b0;
                bubble_cnt_d     = bubble_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q      <= '0;
            bubble_cnt_q <= 8'd0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_out         = stage_q.valid;
    assign pc_out            = stage_q.pc;
    assign val_rn_out        = stage_q.val_rn;
    assign val_rm_out        = stage_q.val_rm;
    assign shift_operand_out = stage_q.shift_operand;
    assign imm_out           = stage_q.imm;
    assign signed_imm24_out  = stage_q.signed_imm24;
    assign dest_out          = stage_q.dest;
    assign src1_out          = stage_q.src1;
    assign src2_out          = stage_q.src2;
    assign exe_cmd_out       = stage_q.exe_cmd;
    assign mem_r_en_out      = stage_q.mem_r_en;
    assign mem_w_en_out      = stage_q.mem_w_en;
    assign wb_en_out         = stage_q.wb_en;
    assign b_out             = stage_q.b;
    assign s_out             = stage_q.s;
    assign status_out        = stage_q.status;
    assign bubble_cnt        = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed scenarios plus randomized traffic against a
// rule-based reference model of the pipeline register.
module tb_id_exe_reg;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, freeze, flush, valid_in;
    logic [DW-1:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0]   shift_operand_in;
    logic          imm_in;
    logic [23:0]   signed_imm24_in;
    logic [3:0]    dest_in, src1_in, src2_in, exe_cmd_in, status_in;
    logic          mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in;

    logic          valid_out;
    logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0]   shift_operand_out;
    logic          imm_out;
    logic [23:0]   signed_imm24_out;
    logic [3:0]    dest_out, src1_out, src2_out, exe_cmd_out, status_out;
    logic          mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out;
    logic [7:0]    bubble_cnt;

    id_exe_reg #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .imm_in(imm_in),
        .signed_imm24_in(signed_imm24_in), .dest_in(dest_in), .src1_in(src1_in),
        .src2_in(src2_in), .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .b_in(b_in), .s_in(s_in),
        .status_in(status_in),
        .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .shift_operand_out(shift_operand_out),
        .imm_out(imm_out), .signed_imm24_out(signed_imm24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .exe_cmd_out(exe_cmd_out),
        .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out),
        .status_out(status_out), .bubble_cnt(bubble_cnt)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected output values, bubble count kept as a plain integer.
    logic [DW-1:0] e_pc, e_rn, e_rm;
    logic [11:0]   e_shift;
    logic [23:0]   e_imm24;
    logic [3:0]    e_dest, e_src1, e_src2, e_cmd, e_status;
    logic          e_valid, e_imm, e_mr, e_mw, e_wb, e_b, e_s;
    int            e_cnt;

    task automatic model_clear();
        {e_pc, e_rn, e_rm, e_shift, e_imm24} = '0;
        {e_dest, e_src1, e_src2, e_cmd, e_status} = '0;
        {e_valid, e_imm, e_mr, e_mw, e_wb, e_b, e_s} = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            e_cnt = 0;
        end else if (flush) begin
            model_clear();
            e_cnt = (e_cnt + 1 > 255) ? 255 : e_cnt + 1;
        end else if (!freeze) begin
            e_valid = valid_in; e_pc = pc_in; e_rn = val_rn_in; e_rm = val_rm_in;
            e_shift = shift_operand_in; e_imm = imm_in; e_imm24 = signed_imm24_in;
            e_dest = dest_in; e_src1 = src1_in; e_src2 = src2_in; e_cmd = exe_cmd_in;
            e_status = status_in;
            e_mr = valid_in & mem_r_en_in; e_mw = valid_in & mem_w_en_in;
            e_wb = valid_in & wb_en_in; e_b = valid_in & b_in; e_s = valid_in & s_in;
            if (!valid_in) e_cnt = (e_cnt + 1 > 255) ? 255 : e_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  64'(valid_out),         64'(e_valid));
        check({tag, ".pc"},     64'(pc_out),            64'(e_pc));
        check({tag, ".rn"},     64'(val_rn_out),        64'(e_rn));
        check({tag, ".rm"},     64'(val_rm_out),        64'(e_rm));
        check({tag, ".shift"},  64'(shift_operand_out), 64'(e_shift));
        check({tag, ".imm"},    64'(imm_out),           64'(e_imm));
        check({tag, ".imm24"},  64'(signed_imm24_out),  64'(e_imm24));
        check({tag, ".dest"},   64'(dest_out),          64'(e_dest));
        check({tag, ".src1"},   64'(src1_out),          64'(e_src1));
        check({tag, ".src2"},   64'(src2_out),          64'(e_src2));
        check({tag, ".cmd"},    64'(exe_cmd_out),       64'(e_cmd));
        check({tag, ".mr"},     64'(mem_r_en_out),      64'(e_mr));
        check({tag, ".mw"},     64'(mem_w_en_out),      64'(e_mw));
        check({tag, ".wb"},     64'(wb_en_out),         64'(e_wb));
        check({tag, ".b"},      64'(b_out),             64'(e_b));
        check({tag, ".s"},      64'(s_out),             64'(e_s));
        check({tag, ".status"}, 64'(status_out),        64'(e_status));
        check({tag, ".cnt"},    64'(bubble_cnt),        64'(e_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic zero_inputs();
        {pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm24_in} = '0;
        {dest_in, src1_in, src2_in, exe_cmd_in, status_in} = '0;
        {valid_in, imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in} = '0;
        {freeze, flush} = '0;
    endtask

    task automatic rand_inputs();
        logic [31:0] r;
        r = $urandom(); rst    = (r[4:0] == 5'd0);
        r = $urandom(); flush  = (r[2:0] == 3'd0);
        r = $urandom(); freeze = (r[1:0] == 2'd0);
        r = $urandom(); valid_in = (r[1:0] != 2'd0);
        pc_in = $urandom(); val_rn_in = $urandom(); val_rm_in = $urandom();
        r = $urandom();
        shift_operand_in = r[11:0]; dest_in = r[15:12]; src1_in = r[19:16];
        src2_in = r[23:20]; exe_cmd_in = r[27:24]; status_in = r[31:28];
        r = $urandom();
        signed_imm24_in = r[23:0];
        {imm_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in} = r[29:24];
    endtask

    int cnt_before;

    initial begin
        rst = 1'b1;
        zero_inputs();
        model_clear();
        e_cnt = 0;
        step("reset");
        rst = 1'b0;

        // Basic load
        valid_in = 1'b1; pc_in = 32'h8; val_rm_in = 32'h1234_5678;
        shift_operand_in = 12'h0A3; wb_en_in = 1'b1;
        step("load");
        check("load_pc", 64'(pc_out), 64'h8);
        check("load_rm", 64'(val_rm_out), 64'h1234_5678);
        check("load_shift", 64'(shift_operand_out), 64'h0A3);
        check("load_wb", 64'(wb_en_out), 64'h1);
        check("load_cnt", 64'(bubble_cnt), 64'h0);

        // Freeze for three edges
        pc_in = 32'h10;
        step("pre_freeze");
        freeze = 1'b1; pc_in = 32'h14;
        for (int i = 0; i < 3; i++) begin
            step("freeze");
            check("freeze_pc", 64'(pc_out), 64'h10);
        end
        freeze = 1'b0;
        step("unfreeze");
        check("unfreeze_pc", 64'(pc_out), 64'h14);

        // Flush overrides freeze
        cnt_before = int'(bubble_cnt);
        flush = 1'b1; freeze = 1'b1; valid_in = 1'b1; wb_en_in = 1'b1; mem_w_en_in = 1'b1;
        step("flush_freeze");
        check("ff_valid", 64'(valid_out), 64'h0);
        check("ff_wb", 64'(wb_en_out), 64'h0);
        check("ff_mw", 64'(mem_w_en_out), 64'h0);
        check("ff_cnt", 64'(bubble_cnt), 64'(cnt_before + 1));

        // Invalid load
        flush = 1'b0; freeze = 1'b0; valid_in = 1'b0; mem_r_en_in = 1'b1; b_in = 1'b1;
        cnt_before = int'(bubble_cnt);
        step("invalid_load");
        check("inv_mr", 64'(mem_r_en_out), 64'h0);
        check("inv_b", 64'(b_out), 64'h0);
        check("inv_cnt", 64'(bubble_cnt), 64'(cnt_before + 1));

        // Saturation
        flush = 1'b1;
        for (int i = 0; i < 300; i++) step("sat");
        check("sat_cnt", 64'(bubble_cnt), 64'd255);
        step("sat_more");
        check("sat_hold", 64'(bubble_cnt), 64'd255);

        // Reset during a stall
        flush = 1'b0; valid_in = 1'b1; pc_in = 32'h20;
        step("pre_stall");
        freeze = 1'b1; pc_in = 32'h24;
        step("stall");
        check("stall_pc", 64'(pc_out), 64'h20);
        rst = 1'b1;
        step("rst_stall");
        check("rst_pc", 64'(pc_out), 64'h0);
        check("rst_cnt", 64'(bubble_cnt), 64'h0);
        rst = 1'b0; freeze = 1'b0; pc_in = 32'h28;
        step("post_rst");
        check("post_rst_pc", 64'(pc_out), 64'h28);
        check("post_rst_valid", 64'(valid_out), 64'h1);

        // Reset pulse between edges has no effect
        rst = 1'b1;
        #2;
        check_all("rst_between");
        rst = 1'b0;
        step("after_glitch");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rand_inputs();
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
